// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default parameters for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam int FLUSH_CYCLES_DEF = 1;
    localparam int MAX_STALL_DEF    = 8;
    localparam int CNT_W_DEF        = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (inc && (value_q != {W{1'b1}})) begin
            value_d = value_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// PC / pipeline-register enable and flush sequencer for the 5-stage pipe,
// with deferred branches, post-branch squash, stall watchdog and counters.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int MAX_STALL    = MAX_STALL_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hz_stall,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_en,
    output logic             stall_watchdog,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int RW = $clog2(MAX_STALL + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_STALL);
    localparam logic [1:0] FL_INIT = 2'(FLUSH_CYCLES - 1);

    state_e        state_q, state_d;
    logic          br_pend_q, br_pend_d;
    logic [1:0]    fl_left_q, fl_left_d;
    logic [RW-1:0] run_len_q, run_len_d;
    logic          wd_q, wd_d;

    logic pc_en_c, ifid_en_c, ifid_fl_c, idex_fl_c, pipe_en_c;
    logic flush_evt;

    always_comb begin
        pc_en_c   = 1'b1;
        ifid_en_c = 1'b1;
        pipe_en_c = 1'b1;
        ifid_fl_c = 1'b0;
        idex_fl_c = 1'b0;
        flush_evt = 1'b0;
        state_d   = state_q;
        br_pend_d = br_pend_q;
        fl_left_d = fl_left_q;
        run_len_d = run_len_q;
        wd_d      = wd_q;

        if (mem_busy) begin
            pc_en_c   = 1'b0;
            ifid_en_c = 1'b0;
            pipe_en_c = 1'b0;
            if (br_taken) begin
                br_pend_d = 1'b1;
            end
        end else if (br_taken || br_pend_q) begin
            ifid_fl_c = 1'b1;
            idex_fl_c = 1'b1;
            flush_evt = 1'b1;
            br_pend_d = 1'b0;
            run_len_d = '0;
            if (FLUSH_CYCLES > 1) begin
                state_d   = FLUSH;
                fl_left_d = FL_INIT;
            end else begin
                state_d   = RUN;
                fl_left_d = '0;
            end
        end else if (state_q == FLUSH) begin
            ifid_fl_c = 1'b1;
            run_len_d = '0;
            fl_left_d = fl_left_q - 2'd1;
            if (fl_left_q <= 2'd1) begin
                state_d   = RUN;
                fl_left_d = '0;
            end
        end else if (hz_stall) begin
            pc_en_c   = 1'b0;
            ifid_en_c = 1'b0;
            idex_fl_c = 1'b1;
            if (run_len_q != RUN_MAX) begin
                run_len_d = run_len_q + RW'(1);
            end
            if (run_len_d == RUN_MAX) begin
                wd_d = 1'b1;
            end
        end else begin
            run_len_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            br_pend_q <= 1'b0;
            fl_left_q <= '0;
            run_len_q <= '0;
            wd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            br_pend_q <= br_pend_d;
            fl_left_q <= fl_left_d;
            run_len_q <= run_len_d;
            wd_q      <= wd_d;
        end
    end

    // Reset overrides act without a clock edge.
    assign pc_en          = rst_n & pc_en_c;
    assign ifid_en        = rst_n & ifid_en_c;
    assign pipe_en        = rst_n & pipe_en_c;
    assign ifid_flush     = ~rst_n | ifid_fl_c;
    assign idex_flush     = ~rst_n | idex_fl_c;
    assign stall_watchdog = rst_n & wd_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rst_n & ~pc_en_c),
        .value (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rst_n & flush_evt),
        .value (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl
// (FLUSH_CYCLES=2, MAX_STALL=8, CNT_W=4).
module tb_pipe_stall_ctrl;

    logic       clk;
    logic       rst_n;
    logic       hz_stall;
    logic       br_taken;
    logic       mem_busy;
    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       pipe_en;
    logic       stall_watchdog;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;

    int total = 0;
    int bad   = 0;

    pipe_stall_ctrl #(
        .FLUSH_CYCLES (2),
        .MAX_STALL    (8),
        .CNT_W        (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hz_stall       (hz_stall),
        .br_taken       (br_taken),
        .mem_busy       (mem_busy),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .pipe_en        (pipe_en),
        .stall_watchdog (stall_watchdog),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks pc_en, ifid_en, pipe_en, ifid_flush, idex_flush together.
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, pc_en, ifid_en, pipe_en, ifid_flush, idex_flush},
            {27'd0, exp});
    endtask

    task automatic step(input logic hz, input logic br, input logic mb);
        @(negedge clk);
        hz_stall = hz;
        br_taken = br;
        mem_busy = mb;
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        hz_stall = 1'b0;
        br_taken = 1'b0;
        mem_busy = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        hz_stall = 1'b0;
        br_taken = 1'b0;
        mem_busy = 1'b0;
        #2;
        chk_ctl("reset_ctl", 5'b000_11);
        chk("reset_wd", {31'd0, stall_watchdog}, 32'd0);
        chk("reset_scnt", {28'd0, stall_cnt}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_ctl("run_ctl", 5'b111_00);
        chk("run_scnt", {28'd0, stall_cnt}, 32'd0);
        chk("run_fcnt", {28'd0, flush_cnt}, 32'd0);

        step(1, 0, 0);
        chk_ctl("hz_ctl", 5'b001_01);
        step(0, 0, 0);
        chk_ctl("hz_after_ctl", 5'b111_00);
        chk("hz_scnt", {28'd0, stall_cnt}, 32'd1);
        chk("hz_wd", {31'd0, stall_watchdog}, 32'd0);

        step(0, 1, 0);
        chk_ctl("br_c0", 5'b111_11);
        step(0, 0, 0);
        chk_ctl("br_c1", 5'b111_10);
        step(0, 0, 0);
        chk_ctl("br_c2", 5'b111_00);
        chk("br_fcnt", {28'd0, flush_cnt}, 32'd1);

        do_reset();
        step(0, 0, 1);
        chk_ctl("mb_c0", 5'b000_00);
        step(0, 1, 1);
        chk_ctl("mb_c1", 5'b000_00);
        step(0, 0, 1);
        chk_ctl("mb_c2", 5'b000_00);
        step(0, 0, 0);
        chk_ctl("mb_br", 5'b111_11);
        chk("mb_scnt", {28'd0, stall_cnt}, 32'd3);
        step(0, 0, 0);
        chk_ctl("mb_fl", 5'b111_10);
        chk("mb_fcnt", {28'd0, flush_cnt}, 32'd1);
        step(0, 0, 0);
        chk_ctl("mb_done", 5'b111_00);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0);
            chk($sformatf("wd_edge%0d", i), {31'd0, stall_watchdog},
                (i >= 8) ? 32'd1 : 32'd0);
        end
        step(0, 0, 0);
        chk("wd_sticky0", {31'd0, stall_watchdog}, 32'd1);
        chk("wd_scnt", {28'd0, stall_cnt}, 32'd10);
        step(0, 0, 0);
        chk("wd_sticky1", {31'd0, stall_watchdog}, 32'd1);

        do_reset();
        chk("wd_cleared", {31'd0, stall_watchdog}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0);
        end
        step(0, 0, 0);
        chk("sat_scnt", {28'd0, stall_cnt}, 32'd15);

        do_reset();
        step(0, 1, 0);
        step(0, 1, 1);
        chk_ctl("pend_busy", 5'b000_00);
        step(0, 0, 1);
        rst_n = 1'b0;
        #1;
        chk_ctl("async_rst_ctl", 5'b000_11);
        chk("async_rst_fcnt", {28'd0, flush_cnt}, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        mem_busy = 1'b0;
        #1;
        chk_ctl("post_rst0", 5'b111_00);
        step(0, 0, 0);
        chk_ctl("post_rst1", 5'b111_00);
        chk("post_rst_fcnt", {28'd0, flush_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
